// File: rtl/matrix_stream_reader.sv
// ---------------------------------------------------------------------------
// matrix_stream_reader
//
// Walks a rows x cols matrix stored in word-addressed data memory and streams
// the elements out over a valid/ready interface. Read addresses are issued
// towards a memory with a fixed 1-cycle read latency. Returned words go into
// a 2-entry skid buffer whose head drives the output stream. When the buffer
// is empty, the word currently returning from memory is presented directly.
// This gives a 1-cycle mem_rd_en -> out_valid latency.
//
// Optional feature (compile-time macro MATRIX_READER_TRANSPOSE_EN):
//   Adds the input `transpose`, which is latched at start. When the latched
//   value is 1, the matrix is walked in column-major order. Without the macro,
//   only row-major order exists and the port is absent.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      launch a traversal (sampled only while idle)
//   base_addr  address of element (0,0), latched at start
//   rows       row count, latched at start
//   cols       column count, latched at start
//   stride     address distance between rows, latched at start
//   transpose  (optional) column-major walk, latched at start
//   mem_rd_en  read strobe; mem_data is returned one cycle later
//   mem_addr   read address, qualified by mem_rd_en
//   mem_data   read return data
//   out_data   streamed element
//   out_valid  out_data valid, held until accepted
//   out_ready  consumer ready
//   out_last   final element marker, qualified by out_valid
//   busy       traversal in progress
//   done       1-cycle pulse after the last element has been accepted
// ---------------------------------------------------------------------------
module matrix_stream_reader #(
    parameter int word_size  = 16,
    parameter int addr_width = 16,
    parameter int dim_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [dim_width-1:0]  rows,
    input  logic [dim_width-1:0]  cols,
    input  logic [dim_width-1:0]  stride,
`ifdef MATRIX_READER_TRANSPOSE_EN
    input  logic                  transpose,
`endif
    output logic                  mem_rd_en,
    output logic [addr_width-1:0] mem_addr,
    input  logic [word_size-1:0]  mem_data,
    output logic [word_size-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [dim_width-1:0]  DIM_ONE  = dim_width'(1);
    localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // The traversal is described as an inner and an outer loop so that both
    // walk orders share a single address generator. For row-major order, the
    // inner loop runs over columns with step 1, and the outer loop advances
    // the base by stride. For column-major order, the inner loop runs over rows
    // and accumulates stride, and the outer loop advances the base by 1.
    logic [dim_width-1:0]  inner_cnt_reg;
    logic [dim_width-1:0]  outer_cnt_reg;
    logic [dim_width-1:0]  inner_max_reg;   // inner dimension - 1
    logic [dim_width-1:0]  outer_max_reg;   // outer dimension - 1
    logic [addr_width-1:0] outer_base_reg;
    logic [addr_width-1:0] inner_off_reg;
    logic [addr_width-1:0] inner_step_reg;
    logic [addr_width-1:0] outer_step_reg;

    // Read in flight: its data is on mem_data in the current cycle.
    logic                  inflight_reg;
    logic                  inflight_last_reg;

    // 2-entry skid buffer (circular).
    logic [word_size-1:0]  fifo_data_reg [2];
    logic                  fifo_last_reg [2];
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic [1:0]            count_reg;

    logic [1:0]            occ;
    logic [1:0]            occ_after_pop;
    logic                  pop;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic                  issue;
    logic                  inner_wrap;
    logic                  final_elem;
    logic                  zero_dim;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign occ           = count_reg + {1'b0, inflight_reg};
    assign out_valid     = (count_reg != 2'd0) || inflight_reg;
    assign pop           = out_valid && out_ready;
    assign occ_after_pop = occ - {1'b0, pop};
    assign issue         = (state_reg == ST_RUN) && (occ_after_pop < 2'd2);

    // A returning word bypasses the buffer only if the buffer is empty and
    // the word is accepted in the same cycle. Otherwise, the word is buffered.
    assign fifo_pop  = pop && (count_reg != 2'd0);
    assign fifo_push = inflight_reg && !(pop && (count_reg == 2'd0));

    assign inner_wrap = (inner_cnt_reg == inner_max_reg);
    assign final_elem = inner_wrap && (outer_cnt_reg == outer_max_reg);
    assign zero_dim   = (rows == '0) || (cols == '0);

    assign mem_rd_en = issue;
    assign mem_addr  = outer_base_reg + inner_off_reg;

    assign busy = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done = (state_reg == ST_DONE);

    // Head of the stream: the buffer head if any, otherwise the bypassed word.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (count_reg != 2'd0) begin
            out_data = fifo_data_reg[rd_ptr_reg];
            out_last = fifo_last_reg[rd_ptr_reg];
        end else if (inflight_reg) begin
            out_data = mem_data;
            out_last = inflight_last_reg;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = zero_dim ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && final_elem) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ_after_pop == 2'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            inner_cnt_reg  <= '0;
            outer_cnt_reg  <= '0;
            inner_max_reg  <= '0;
            outer_max_reg  <= '0;
            outer_base_reg <= '0;
            inner_off_reg  <= '0;
            inner_step_reg <= '0;
            outer_step_reg <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            inner_cnt_reg  <= '0;
            outer_cnt_reg  <= '0;
            outer_base_reg <= base_addr;
            inner_off_reg  <= '0;
`ifdef MATRIX_READER_TRANSPOSE_EN
            if (transpose) begin
                inner_max_reg  <= rows - DIM_ONE;
                outer_max_reg  <= cols - DIM_ONE;
                inner_step_reg <= addr_width'(stride);
                outer_step_reg <= ADDR_ONE;
            end else begin
                inner_max_reg  <= cols - DIM_ONE;
                outer_max_reg  <= rows - DIM_ONE;
                inner_step_reg <= ADDR_ONE;
                outer_step_reg <= addr_width'(stride);
            end
`else
            inner_max_reg  <= cols - DIM_ONE;
            outer_max_reg  <= rows - DIM_ONE;
            inner_step_reg <= ADDR_ONE;
            outer_step_reg <= addr_width'(stride);
`endif
        end else if (issue) begin
            if (inner_wrap) begin
                inner_cnt_reg  <= '0;
                inner_off_reg  <= '0;
                outer_cnt_reg  <= outer_cnt_reg + DIM_ONE;
                outer_base_reg <= outer_base_reg + outer_step_reg;
            end else begin
                inner_cnt_reg  <= inner_cnt_reg + DIM_ONE;
                inner_off_reg  <= inner_off_reg + inner_step_reg;
            end
        end
    end

    // In-flight tracking: clearing on reset drops any word returning in the
    // cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= issue && final_elem;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // Buffer storage has no reset; the count guards its contents.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (fifo_push && (wr_ptr_reg == 1'(gi))) begin
                fifo_data_reg[gi] <= mem_data;
                fifo_last_reg[gi] <= inflight_last_reg;
            end
        end
    end

endmodule
